uart_rs232_rx_param: RTL and testbench

Parametrised RS-232 receiver, the successor to the fixed 8-bit receiver in the UART_232 path. It runs in the single system clock domain and uses the baud `Tick` as a clock enable. It provides:
- a 2-flop input synchroniser;
- majority-vote sampling at a configurable oversample ratio;
- runtime-selectable data length, stop bits and parity;
- framing, parity and overrun error reporting;
- a valid/ready output holding register for the downstream consumer.

---
 rtl/uart_rs232_rx_param_if.sv | 30 +++
 rtl/uart_rs232_rx_param.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_rs232_rx_param.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rs232_rx_param_if.sv
// Receiver output bus: holding register contents plus the valid/ready
// handshake toward the downstream consumer.
interface uart_rs232_rx_param_if #(
  parameter int DATA_MAX = 8
);
  logic [DATA_MAX-1:0] RxData;
  logic                RxValid;
  logic                RxReady;
  logic                FrameErr;
  logic                ParErr;
  logic                Overrun;

  modport master (
    output RxData,
    output RxValid,
    output FrameErr,
    output ParErr,
    output Overrun,
    input  RxReady
  );

  modport slave (
    input  RxData,
    input  RxValid,
    input  FrameErr,
    input  ParErr,
    input  Overrun,
    output RxReady
  );
endinterface

// File: rtl/uart_rs232_rx_param.sv
// Parametrised RS-232 receiver: 2-flop synchroniser, 3-sample majority vote,
// runtime data length / stop bits / parity, framing/parity/overrun flags and
// a valid/ready holding register.
// Optional feature macro: UART_RX_PARITY_EN (parity state and checker).
// DATA_MAX legal range 5..9; OVERSAMPLE must be even and >= 8.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for a Tick that sees rxs=0 with RxEn=1
// S_START  | start bit; a voted 1 is a false start and aborts
// S_DATA   | data bits shifted in LSB-first, shadow NBits of them
// S_PARITY | parity bit folded into the XOR accumulator (macro only)
// S_STOP   | one or two stop bits; frame completes at last decision
module uart_rs232_rx_param #(
  parameter int DATA_MAX   = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       RxEn,
  input  logic       Rx,
  input  logic [3:0] NBits,
  input  logic       TwoStop,
  input  logic       ParityEn,
  input  logic       ParityOdd,
  output logic       Busy,
  uart_rs232_rx_param_if.master rx_if
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [CW-1:0] CNT_V0   = CW'(M - 1);
  localparam logic [CW-1:0] CNT_V1   = CW'(M);
  localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    NB_MIN   = 4'd5;
  localparam logic [3:0]    NB_MAX   = 4'(DATA_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                rx_meta, rxs;
  logic [CW-1:0]       cnt;
  logic                v0, v1;
  logic [3:0]          bit_idx;
  logic [DATA_MAX-1:0] shreg;
  logic                stop_idx;
  logic                frm_acc;
  logic [3:0]          nbits_sh;
  logic                two_stop_sh;
  logic [3:0]          nbits_clamped;

`ifdef UART_RX_PARITY_EN
  logic                par_en_sh;
  logic                par_odd_sh;
  logic                par_acc;
`else
  // Parity inputs have no function in this build.
  logic                unused_par;
  assign unused_par = ParityEn ^ ParityOdd;
`endif

  logic                in_frame, start_det, decide, bit_end, vote;
  logic                false_start, last_data, done;
  logic                frame_frm, frame_par;

  logic [DATA_MAX-1:0] data_q;
  logic                valid_q, frm_q, par_q, ovr_q;

  // Synchronise the asynchronous line; idle-high reset avoids a false start.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rxs     <= rx_meta;
    end
  end

  // Clamp the requested data length into the supported range.
  always_comb begin
    nbits_clamped = NBits;
    if (NBits < NB_MIN)      nbits_clamped = NB_MIN;
    else if (NBits > NB_MAX) nbits_clamped = NB_MAX;
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_det) state_d = S_START;
      end
      S_START: begin
        if (false_start)  state_d = S_IDLE;
        else if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && last_data) begin
`ifdef UART_RX_PARITY_EN
          state_d = par_en_sh ? S_PARITY : S_STOP;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: timing strobes, majority vote and frame completion.
  always_comb begin
    in_frame    = (state_q != S_IDLE);
    start_det   = Tick && RxEn && !rxs && (state_q == S_IDLE);
    decide      = Tick && in_frame && (cnt == CNT_DEC);
    bit_end     = Tick && in_frame && (cnt == CNT_LAST);
    vote        = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
    false_start = (state_q == S_START) && decide && vote;
    last_data   = (bit_idx == (nbits_sh - 4'd1));
    done        = (state_q == S_STOP) && decide && (stop_idx == two_stop_sh);
    frame_frm   = frm_acc | ~vote;
`ifdef UART_RX_PARITY_EN
    frame_par   = par_en_sh & (par_acc != par_odd_sh);
`else
    frame_par   = 1'b0;
`endif
    Busy        = in_frame;
  end

  // Bit timing, vote samples, shift register and per-frame accumulators.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt         <= '0;
      v0          <= 1'b1;
      v1          <= 1'b1;
      bit_idx     <= '0;
      shreg       <= '0;
      stop_idx    <= 1'b0;
      frm_acc     <= 1'b0;
      nbits_sh    <= NB_MIN;
      two_stop_sh <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_sh   <= 1'b0;
      par_odd_sh  <= 1'b0;
      par_acc     <= 1'b0;
`endif
    end else if (start_det) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      stop_idx    <= 1'b0;
      frm_acc     <= 1'b0;
      nbits_sh    <= nbits_clamped;
      two_stop_sh <= TwoStop;
`ifdef UART_RX_PARITY_EN
      par_en_sh   <= ParityEn;
      par_odd_sh  <= ParityOdd;
      par_acc     <= 1'b0;
`endif
    end else if (Tick && in_frame) begin
      cnt <= bit_end ? '0 : cnt + CW'(1);
      if (cnt == CNT_V0) v0 <= rxs;
      if (cnt == CNT_V1) v1 <= rxs;
      if (state_q == S_DATA && decide) begin
        for (int i = 0; i < DATA_MAX; i++) begin
          if (bit_idx == 4'(i)) shreg[i] <= vote;
        end
`ifdef UART_RX_PARITY_EN
        par_acc <= par_acc ^ vote;
`endif
      end
      if (state_q == S_DATA && bit_end) bit_idx <= bit_idx + 4'd1;
`ifdef UART_RX_PARITY_EN
      if (state_q == S_PARITY && decide) par_acc <= par_acc ^ vote;
`endif
      if (state_q == S_STOP && decide && !vote) frm_acc  <= 1'b1;
      if (state_q == S_STOP && bit_end)         stop_idx <= 1'b1;
    end
  end

  // Holding register: load on completion if free (or draining this cycle),
  // otherwise drop the frame and flag overrun until the next transfer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      frm_q   <= 1'b0;
      par_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (done && (!valid_q || rx_if.RxReady)) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
        frm_q   <= frame_frm;
        par_q   <= frame_par;
      end else if (valid_q && rx_if.RxReady) begin
        valid_q <= 1'b0;
      end
      if (valid_q && rx_if.RxReady) ovr_q <= 1'b0;
      else if (done && valid_q)     ovr_q <= 1'b1;
    end
  end

  assign rx_if.RxData   = data_q;
  assign rx_if.RxValid  = valid_q;
  assign rx_if.FrameErr = frm_q;
  assign rx_if.ParErr   = par_q;
  assign rx_if.Overrun  = ovr_q;

endmodule

// File: tb/tb_uart_rs232_rx_param.sv
// Bench for uart_rs232_rx_param (DATA_MAX=9, OVERSAMPLE=16). Expected parity
// outcomes depend on whether UART_RX_PARITY_EN is defined for the build.
module tb_uart_rs232_rx_param;
  localparam int DW = 9;
  localparam int OS = 16;

  logic       Clk = 1'b0;
  logic       Rst, Tick, RxEn, Rx, TwoStop, ParityEn, ParityOdd, Busy;
  logic [3:0] NBits;

  uart_rs232_rx_param_if #(.DATA_MAX(DW)) rx_if ();

  uart_rs232_rx_param #(.DATA_MAX(DW), .OVERSAMPLE(OS)) dut (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .RxEn(RxEn), .Rx(Rx),
    .NBits(NBits), .TwoStop(TwoStop), .ParityEn(ParityEn),
    .ParityOdd(ParityOdd), .Busy(Busy), .rx_if(rx_if)
  );

  always #5 Clk = ~Clk;

  // One-Clk Tick every third cycle.
  initial begin
    Tick = 1'b0;
    forever begin
      repeat (2) @(posedge Clk);
      #1 Tick = 1'b1;
      @(posedge Clk);
      #1 Tick = 1'b0;
    end
  end

  typedef struct packed {
    logic [8:0] data;
    logic       frm;
    logic       par;
  } exp_t;

  typedef struct {
    logic [8:0] data;
    logic [3:0] nbits;
    logic       two_stop;
    logic       par_en;
    logic       par_odd;
    logic       pbit;
    logic       s1;
    logic       s2;
    logic [8:0] exp_data;
    logic       exp_frm;
    logic       exp_par;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   valid_cycles = 0;
  vec_t vt[13];

`ifdef UART_RX_PARITY_EN
  localparam logic PDEF = 1'b1;
`else
  localparam logic PDEF = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: every transfer pops one expected word.
  always @(negedge Clk) begin
    exp_t e;
    if (!Rst && rx_if.RxValid) valid_cycles++;
    if (!Rst && rx_if.RxValid && rx_if.RxReady) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got data %0h frm %0b par %0b expected none",
                 rx_if.RxData, rx_if.FrameErr, rx_if.ParErr);
      end else begin
        e = sb_q.pop_front();
        if ({rx_if.RxData, rx_if.FrameErr, rx_if.ParErr} !== {e.data, e.frm, e.par}) begin
          errors++;
          $display("FAIL word got data %0h frm %0b par %0b expected data %0h frm %0b par %0b",
                   rx_if.RxData, rx_if.FrameErr, rx_if.ParErr, e.data, e.frm, e.par);
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk);
      while (Tick !== 1'b1) @(posedge Clk);
    end
    #1;
  endtask

  function automatic int line_bits(input logic [3:0] nb);
    if (nb < 4'd5) return 5;
    if (nb > 4'(DW)) return DW;
    return int'(nb);
  endfunction

  task automatic send_frame(input logic [8:0] data, input int nb, input logic has_par,
                            input logic pbit, input logic two, input logic s1, input logic s2);
    Rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < nb; i++) begin
      Rx = data[i];
      wait_ticks(OS);
    end
    if (has_par) begin
      Rx = pbit;
      wait_ticks(OS);
    end
    Rx = s1;
    wait_ticks(OS);
    if (two) begin
      Rx = s2;
      wait_ticks(OS);
    end
    Rx = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  task automatic run_frame(input vec_t v);
    int vc0;
    exp_t e;
    NBits    = v.nbits;
    TwoStop  = v.two_stop;
    ParityEn = v.par_en;
    ParityOdd = v.par_odd;
    e.data = v.exp_data;
    e.frm  = v.exp_frm;
    e.par  = v.exp_par;
    sb_q.push_back(e);
    vc0 = valid_cycles;
    send_frame(v.data, line_bits(v.nbits), v.par_en, v.pbit, v.two_stop, v.s1, v.s2);
    wait_ticks(24);
    wait_drain();
    chk("valid_len", valid_cycles - vc0, 1);
  endtask

  function automatic vec_t mk(input logic [8:0] d, input logic [3:0] nb, input logic two,
                              input logic pen, input logic podd, input logic pbit,
                              input logic s1, input logic s2, input logic [8:0] ed,
                              input logic ef, input logic ep);
    vec_t v;
    v.data = d; v.nbits = nb; v.two_stop = two; v.par_en = pen; v.par_odd = podd;
    v.pbit = pbit; v.s1 = s1; v.s2 = s2; v.exp_data = ed; v.exp_frm = ef; v.exp_par = ep;
    return v;
  endfunction

  initial begin
    int vc0;
    vec_t v;
    Rst = 1'b1; RxEn = 1'b1; Rx = 1'b1; NBits = 4'd8; TwoStop = 1'b0;
    ParityEn = 1'b0; ParityOdd = 1'b0; rx_if.RxReady = 1'b1;

    //             data    nb   two pen odd pbit s1 s2  exp_data frm            par
    vt[0]  = mk(9'h0A5, 4'd8,  0,  0,  0,  0,   1, 1, 9'h0A5, 1'b0,          1'b0);
    vt[1]  = mk(9'h041, 4'd7,  0,  1,  0,  1,   1, 1, 9'h041, 1'b0,          PDEF);
    vt[2]  = mk(9'h041, 4'd7,  0,  1,  0,  0,   1, 1, 9'h041, ~PDEF,         1'b0);
    vt[3]  = mk(9'h07E, 4'd8,  1,  0,  0,  0,   1, 0, 9'h07E, 1'b1,          1'b0);
    vt[4]  = mk(9'h03C, 4'd8,  0,  1,  1,  1,   1, 1, 9'h03C, 1'b0,          1'b0);
    vt[5]  = mk(9'h155, 4'd9,  0,  0,  0,  0,   1, 1, 9'h155, 1'b0,          1'b0);
    vt[6]  = mk(9'h0AB, 4'd12, 0,  0,  0,  0,   1, 1, 9'h0AB, 1'b0,          1'b0);
    vt[7]  = mk(9'h013, 4'd3,  0,  0,  0,  0,   1, 1, 9'h013, 1'b0,          1'b0);
    vt[8]  = mk(9'h000, 4'd8,  0,  0,  0,  0,   0, 1, 9'h000, 1'b1,          1'b0);
    vt[9]  = mk(9'h02D, 4'd6,  1,  1,  0,  0,   1, 1, 9'h02D, ~PDEF,         1'b0);
    vt[10] = mk(9'h01F, 4'd5,  0,  0,  0,  0,   1, 1, 9'h01F, 1'b0,          1'b0);
    vt[11] = mk(9'h0D2, 4'd8,  0,  1,  0,  1,   1, 1, 9'h0D2, 1'b0,          PDEF);
    vt[12] = mk(9'h0D2, 4'd8,  0,  1,  1,  0,   1, 1, 9'h0D2, ~PDEF,         PDEF);

    repeat (4) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("rst_data",  rx_if.RxData,   0);
    chk("rst_valid", rx_if.RxValid,  0);
    chk("rst_frm",   rx_if.FrameErr, 0);
    chk("rst_par",   rx_if.ParErr,   0);
    chk("rst_ovr",   rx_if.Overrun,  0);
    chk("rst_busy",  Busy,           0);
    @(posedge Clk); #1;

    for (int i = 0; i < 13; i++) run_frame(vt[i]);

    // Glitch: 4 ticks low is a false start, then a clean 0x3C.
    NBits = 4'd8; TwoStop = 1'b0; ParityEn = 1'b0;
    vc0 = valid_cycles;
    Rx = 1'b0;
    wait_ticks(4);
    chk("glitch_busy_hi", Busy, 1);
    Rx = 1'b1;
    wait_ticks(12);
    chk("glitch_busy_lo", Busy, 0);
    chk("glitch_no_valid", valid_cycles - vc0, 0);
    run_frame(mk(9'h03C, 4'd8, 0, 0, 0, 0, 1, 1, 9'h03C, 1'b0, 1'b0));

    // RxEn low: no start detected.
    RxEn = 1'b0;
    Rx = 1'b0;
    wait_ticks(8);
    chk("rxen_busy", Busy, 0);
    Rx = 1'b1;
    wait_ticks(16);
    RxEn = 1'b1;

    // Overrun: 0x11 held, 0x22 dropped, one-cycle ready drains 0x11.
    rx_if.RxReady = 1'b0;
    v = mk(9'h011, 4'd8, 0, 0, 0, 0, 1, 1, 9'h011, 1'b0, 1'b0);
    sb_q.push_back({9'h011, 1'b0, 1'b0});
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_ticks(24);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_ticks(24);
    @(negedge Clk);
    chk("ovr_data",  rx_if.RxData,  v.exp_data);
    chk("ovr_valid", rx_if.RxValid, 1);
    chk("ovr_flag",  rx_if.Overrun, 1);
    @(posedge Clk); #1 rx_if.RxReady = 1'b1;
    @(posedge Clk); #1 rx_if.RxReady = 1'b0;
    @(negedge Clk);
    chk("ovr_cleared", rx_if.Overrun, 0);
    chk("ovr_valid_lo", rx_if.RxValid, 0);
    chk("ovr_drained", sb_q.size(), 0);

    // Reset mid-frame with a held word and overrun pending.
    send_frame(9'h066, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_ticks(24);
    send_frame(9'h077, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_ticks(24);
    @(negedge Clk);
    chk("pre_rst_data", rx_if.RxData, 9'h066);
    chk("pre_rst_ovr",  rx_if.Overrun, 1);
    @(posedge Clk); #1;
    Rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      Rx = 1'(9'h099 >> i);
      wait_ticks(OS);
    end
    Rx = 1'b1;
    wait_ticks(8);
    chk("mid_busy", Busy, 1);
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("mr_data",  rx_if.RxData,   0);
    chk("mr_valid", rx_if.RxValid,  0);
    chk("mr_frm",   rx_if.FrameErr, 0);
    chk("mr_par",   rx_if.ParErr,   0);
    chk("mr_ovr",   rx_if.Overrun,  0);
    chk("mr_busy",  Busy,           0);
    @(posedge Clk); #1;
    rx_if.RxReady = 1'b1;
    wait_ticks(24);
    run_frame(mk(9'h05A, 4'd8, 0, 0, 0, 0, 1, 1, 9'h05A, 1'b0, 1'b0));

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 60000);
    errors++;
    $display("FAIL timeout got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
